modmul_arb: RTL and testbench

- Round-robin arbiter and pipeline controller that shares one modular multiplier between two requesters. The multiplier is a 12x12 multiply followed by the team's Kyber Barrett reducer (red_K, q = 3329).
- Typical requesters are the NTT butterfly engine (port 0) and the pointwise polynomial multiplier (port 1).
- Each accepted request returns a*b mod 3329 to the requester that issued it, tagged, after a fixed latency.

---
 rtl/modmul_arb.sv | 104 ++++++++++
 tb/tb_modmul_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modmul_arb.sv
// Two-port round-robin front end for a shared 12x12 multiplier with Kyber
// Barrett reduction (q = 3329); three-stage pipeline, one result per cycle.
module modmul_arb #(
  parameter int TAG_W = 4,
  parameter int Q     = 3329
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [11:0]      req_a0_i,
  input  logic [11:0]      req_b0_i,
  input  logic [TAG_W-1:0] req_tag0_i,
  input  logic [11:0]      req_a1_i,
  input  logic [11:0]      req_b1_i,
  input  logic [TAG_W-1:0] req_tag1_i,
  output logic [1:0]       rsp_valid_o,
  output logic [11:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o,
  output logic             prio_o
);

  localparam int DATA_W    = 12;
  localparam int PROD_W    = 2 * DATA_W;
  localparam int BARRETT_K = 26;
  localparam int BM_W      = 15;
  localparam int XM_W      = PROD_W + BM_W;
  localparam logic [BM_W-1:0]   BARRETT_M = BM_W'((64'd1 << BARRETT_K) / Q);
  localparam logic [PROD_W-1:0] Q_P       = PROD_W'(Q);

  // Barrett estimate undershoots the true quotient by at most one for any
  // 24-bit product, so a single conditional subtract lands in 0..q-1.
  function automatic logic [DATA_W-1:0] red_k(input logic [PROD_W-1:0] x);
    logic [XM_W-1:0]   xm;
    logic [PROD_W-1:0] qt;
    logic [PROD_W-1:0] r;
    xm = {{BM_W{1'b0}}, x} * {{PROD_W{1'b0}}, BARRETT_M};
    qt = PROD_W'(xm[XM_W-1:BARRETT_K]);
    r  = x - qt * Q_P;
    if (r >= Q_P) r = r - Q_P;
    return r[DATA_W-1:0];
  endfunction

  logic              acc;
  logic              vld_p0, vld_p1;
  logic              id_p0, id_p1;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic [TAG_W-1:0]  tag_p0, tag_p1;
  logic [PROD_W-1:0] prod_p1;

  always_comb begin
    req_ready_o = 2'b00;
    if (!rst_i) begin
      if (req_valid_i == 2'b11) req_ready_o = prio_o ? 2'b10 : 2'b01;
      else                      req_ready_o = req_valid_i;
    end
  end

  assign acc = |req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_o      <= 1'b0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      rsp_valid_o <= 2'b00;
      rsp_data_o  <= '0;
      rsp_tag_o   <= '0;
    end else begin
      if (acc) prio_o <= ~req_ready_o[1];
      vld_p0      <= acc;
      vld_p1      <= vld_p0;
      rsp_valid_o <= {vld_p1 & id_p1, vld_p1 & ~id_p1};
      // stage p2: reduced result and tag drive the response port
      if (vld_p1) begin
        rsp_data_o <= red_k(prod_p1);
        rsp_tag_o  <= tag_p1;
      end
    end
  end

  // stage p0: capture the granted requester's operands
  always_ff @(posedge clk_i) begin
    if (acc) begin
      a_p0   <= req_ready_o[1] ? req_a1_i   : req_a0_i;
      b_p0   <= req_ready_o[1] ? req_b1_i   : req_b0_i;
      tag_p0 <= req_ready_o[1] ? req_tag1_i : req_tag0_i;
      id_p0  <= req_ready_o[1];
    end
  end

  // stage p1: full-width unsigned product
  always_ff @(posedge clk_i) begin
    if (vld_p0) begin
      prod_p1 <= PROD_W'(a_p0) * PROD_W'(b_p0);
      tag_p1  <= tag_p0;
      id_p1   <= id_p0;
    end
  end

  assign busy_o = vld_p0 | vld_p1 | (|rsp_valid_o);

endmodule

// File: tb/tb_modmul_arb.sv
// Directed and randomized checks of modmul_arb against hand-computed values
// and a plain (a*b) % 3329 reference with per-port ordered scoreboards.
module tb_modmul_arb;
  localparam int TAG_W = 4;
  localparam int Q     = 3329;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [1:0]       req_valid_i, req_ready_o, rsp_valid_o;
  logic [11:0]      req_a0_i, req_b0_i, req_a1_i, req_b1_i, rsp_data_o;
  logic [TAG_W-1:0] req_tag0_i, req_tag1_i, rsp_tag_o;
  logic             busy_o, prio_o;

  logic [11:0] exp0, exp1;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rsp = 0;
  int          eq0[$];
  int          eq1[$];
  int          mon_e;
  bit          mon_on = 1'b0;
  logic [1:0]  rdy;

  modmul_arb #(.TAG_W(TAG_W), .Q(Q)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a0_i(req_a0_i), .req_b0_i(req_b0_i), .req_tag0_i(req_tag0_i),
    .req_a1_i(req_a1_i), .req_b1_i(req_b1_i), .req_tag1_i(req_tag1_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o),
    .busy_o(busy_o), .prio_o(prio_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input int a, input int b, input int t, input int e);
    if (port == 0) begin
      req_a0_i = 12'(a); req_b0_i = 12'(b); req_tag0_i = TAG_W'(t); exp0 = 12'(e);
      req_valid_i[0] = 1'b1;
    end else begin
      req_a1_i = 12'(a); req_b1_i = 12'(b); req_tag1_i = TAG_W'(t); exp1 = 12'(e);
      req_valid_i[1] = 1'b1;
    end
  endtask

  task automatic do_reset();
    req_valid_i = 2'b00;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // response scoreboard; acceptance is sampled mid-cycle when inputs are settled
  always @(negedge clk) begin
    if (mon_on) begin
      chk("ready_onehot", 32'(req_ready_o == 2'b11), 0);
      chk("ready_without_valid", 32'(req_ready_o & ~req_valid_i), 0);
      chk("rsp_onehot", 32'(rsp_valid_o == 2'b11), 0);
      if (rsp_valid_o[0]) begin
        n_rsp++;
        if (eq0.size() == 0) chk("rsp0_unexpected", 1, 0);
        else begin
          mon_e = eq0.pop_front();
          chk("rsp0_data", 32'(rsp_data_o), 32'(mon_e[15:4]));
          chk("rsp0_tag", 32'(rsp_tag_o), 32'(mon_e[3:0]));
        end
      end
      if (rsp_valid_o[1]) begin
        n_rsp++;
        if (eq1.size() == 0) chk("rsp1_unexpected", 1, 0);
        else begin
          mon_e = eq1.pop_front();
          chk("rsp1_data", 32'(rsp_data_o), 32'(mon_e[15:4]));
          chk("rsp1_tag", 32'(rsp_tag_o), 32'(mon_e[3:0]));
        end
      end
      if (rst_i) begin
        eq0.delete();
        eq1.delete();
      end else begin
        if (req_valid_i[0] && req_ready_o[0]) eq0.push_back(int'({16'd0, exp0, req_tag0_i}));
        if (req_valid_i[1] && req_ready_o[1]) eq1.push_back(int'({16'd0, exp1, req_tag1_i}));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ta[4] = '{3328, 0, 2000, 1};
  int tb[4] = '{3328, 2000, 2000, 3328};
  int te[4] = '{1, 0, 1871, 3328};
  int ba[8] = '{1, 2, 3328, 100, 3000, 1664, 55, 0};
  int bb[8] = '{1, 1665, 2, 100, 3000, 2, 61, 0};
  int be[8] = '{1, 1, 3327, 13, 1713, 3328, 26, 0};

  initial begin
    bit pend0, pend1;
    int iss0, iss1, cyc, rsp_base;

    req_a0_i = '0; req_b0_i = '0; req_tag0_i = '0;
    req_a1_i = '0; req_b1_i = '0; req_tag1_i = '0;
    exp0 = '0; exp1 = '0;
    req_valid_i = 2'b11;
    rst_i = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("rst_rsp_data", 32'(rsp_data_o), 0);
    chk("rst_rsp_tag", 32'(rsp_tag_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_prio", 32'(prio_o), 0);
    req_valid_i = 2'b00;
    rst_i = 1'b0;
    mon_on = 1'b1;
    tick();

    // single request, exact latency and drain
    drive(0, 1234, 5, 3, 2841);
    #1 chk("t1_ready", 32'(req_ready_o), 1);
    tick();
    req_valid_i = 2'b00;
    chk("t1_lat_e0", 32'(rsp_valid_o), 0);
    chk("t1_busy_e0", 32'(busy_o), 1);
    tick();
    chk("t1_lat_e1", 32'(rsp_valid_o), 0);
    tick();
    chk("t1_valid", 32'(rsp_valid_o), 1);
    chk("t1_data", 32'(rsp_data_o), 2841);
    chk("t1_tag", 32'(rsp_tag_o), 3);
    chk("t1_busy_e2", 32'(busy_o), 1);
    tick();
    chk("t1_busy_drained", 32'(busy_o), 0);
    chk("t1_valid_drop", 32'(rsp_valid_o), 0);
    chk("t1_data_hold", 32'(rsp_data_o), 2841);

    // boundary operands on requester 1
    for (int i = 0; i < 4; i++) begin
      drive(1, ta[i], tb[i], 5 + i, te[i]);
      #1 chk("t2_ready", 32'(req_ready_o), 2);
      tick();
      req_valid_i = 2'b00;
      tick();
      tick();
      chk("t2_valid", 32'(rsp_valid_o), 2);
      chk("t2_data", 32'(rsp_data_o), 32'(te[i]));
      chk("t2_tag", 32'(rsp_tag_o), 32'(5 + i));
    end

    // continuous contention from reset
    do_reset();
    drive(0, 17, 17, 0, 289);
    drive(1, 2000, 2000, 0, 1871);
    for (int i = 0; i < 6; i++) begin
      #1 chk("t3_grant", 32'(req_ready_o), (i % 2 == 0) ? 1 : 2);
      rdy = req_ready_o;
      tick();
      if (rdy[0]) req_tag0_i = req_tag0_i + 1'b1;
      if (rdy[1]) req_tag1_i = req_tag1_i + 1'b1;
    end
    req_valid_i = 2'b00;
    repeat (4) tick();
    chk("t3_drained", 32'(busy_o), 0);

    // back-to-back single requester
    do_reset();
    chk("t4_prio_start", 32'(prio_o), 0);
    for (int i = 0; i <= 10; i++) begin
      if (i < 8) drive(0, ba[i], bb[i], i, be[i]);
      else req_valid_i = 2'b00;
      #1;
      if (i < 8) chk("t4_ready", 32'(req_ready_o), 1);
      tick();
      if (i < 8) chk("t4_prio", 32'(prio_o), 1);
      if (i >= 2 && i <= 9) chk("t4_pulse", 32'(rsp_valid_o), 1);
      if (i == 10) chk("t4_pulse_end", 32'(rsp_valid_o), 0);
    end

    // reset with two entries in flight
    do_reset();
    drive(0, 1234, 5, 3, 2841);
    tick();
    drive(0, 17, 17, 1, 289);
    tick();
    req_valid_i = 2'b00;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_prio", 32'(prio_o), 0);
    chk("t5_valid_e0", 32'(rsp_valid_o), 0);
    tick();
    chk("t5_valid_e1", 32'(rsp_valid_o), 0);
    tick();
    chk("t5_valid_e2", 32'(rsp_valid_o), 0);

    // randomized traffic on both ports
    pend0 = 1'b0; pend1 = 1'b0;
    iss0 = 0; iss1 = 0; cyc = 0;
    rsp_base = n_rsp;
    while ((iss0 < 5000 || iss1 < 5000 || pend0 || pend1) && cyc < 60000) begin
      if (!pend0 && iss0 < 5000 && $urandom_range(0, 3) != 0) begin
        req_a0_i = 12'($urandom_range(0, 3328));
        req_b0_i = 12'($urandom_range(0, 3328));
        req_tag0_i = TAG_W'($urandom);
        exp0 = 12'((int'(req_a0_i) * int'(req_b0_i)) % Q);
        pend0 = 1'b1;
        iss0++;
      end
      if (!pend1 && iss1 < 5000 && $urandom_range(0, 3) != 0) begin
        req_a1_i = 12'($urandom_range(0, 3328));
        req_b1_i = 12'($urandom_range(0, 3328));
        req_tag1_i = TAG_W'($urandom);
        exp1 = 12'((int'(req_a1_i) * int'(req_b1_i)) % Q);
        pend1 = 1'b1;
        iss1++;
      end
      req_valid_i = {pend1, pend0};
      #1 rdy = req_ready_o;
      tick();
      cyc++;
      if (rdy[0]) pend0 = 1'b0;
      if (rdy[1]) pend1 = 1'b0;
    end
    chk("t6_no_timeout", 32'(cyc < 60000), 1);
    req_valid_i = 2'b00;
    repeat (5) tick();
    chk("t6_rsp_count", 32'(n_rsp - rsp_base), 10000);
    chk("t6_q0_empty", 32'(eq0.size()), 0);
    chk("t6_q1_empty", 32'(eq1.size()), 0);
    chk("t6_busy", 32'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
